// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate and commit, out-of-order multi-port writeback,
// operand lookup with same-cycle bypass, and flush on a mispredicted branch at the head.
module reorder_buffer #(
    parameter int DEPTH    = 8,
    parameter int WB_PORTS = 2,
    parameter int DATA_W   = 32,
    localparam int IW      = $clog2(DEPTH)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         alloc_valid_in,
    input  logic                         alloc_has_rd_in,
    input  logic [4:0]                   alloc_rd_in,
    output logic                         alloc_ready_out,
    output logic [IW-1:0]                alloc_idx_out,
    input  logic [WB_PORTS-1:0]          wb_valid_in,
    input  logic [WB_PORTS*IW-1:0]       wb_idx_in,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_data_in,
    input  logic [WB_PORTS-1:0]          wb_mispredict_in,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_target_in,
    input  logic [IW-1:0]                q1_idx_in,
    input  logic [IW-1:0]                q2_idx_in,
    output logic                         q1_ready_out,
    output logic                         q2_ready_out,
    output logic [DATA_W-1:0]            q1_data_out,
    output logic [DATA_W-1:0]            q2_data_out,
    output logic                         commit_valid_out,
    output logic                         commit_we_out,
    output logic [4:0]                   commit_rd_out,
    output logic [DATA_W-1:0]            commit_data_out,
    output logic [IW-1:0]                commit_idx_out,
    output logic                         flush_out,
    output logic [DATA_W-1:0]            flush_pc_out,
    output logic [DEPTH-1:0]             flush_mask_out,
    output logic [IW:0]                  count_out
);

    // state      | meaning
    // ST_EMPTY   | slot free
    // ST_PENDING | allocated, waiting for its result
    // ST_DONE    | result present, may retire when at head
    typedef enum logic [1:0] {ST_EMPTY, ST_PENDING, ST_DONE} ent_state_t;

    ent_state_t          ent_st   [DEPTH];
    logic                ent_has  [DEPTH];
    logic [4:0]          ent_rd   [DEPTH];
    logic [DATA_W-1:0]   ent_data [DEPTH];
    logic                ent_mp   [DEPTH];
    logic [DATA_W-1:0]   ent_tgt  [DEPTH];

    logic [IW-1:0]       head, tail;
    logic [IW:0]         count;

    logic [DEPTH-1:0]    wb_hit;
    logic [DATA_W-1:0]   wb_val [DEPTH];
    logic                wb_mp  [DEPTH];
    logic [DATA_W-1:0]   wb_tgt [DEPTH];
    logic                alloc_fire;

    // Per-entry writeback merge; later ports overwrite earlier ones.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wb_hit[i] = 1'b0;
            wb_val[i] = '0;
            wb_mp[i]  = 1'b0;
            wb_tgt[i] = '0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid_in[p] && wb_idx_in[p*IW +: IW] == IW'(i)) begin
                    wb_hit[i] = 1'b1;
                    wb_val[i] = wb_data_in[p*DATA_W +: DATA_W];
                    wb_mp[i]  = wb_mispredict_in[p];
                    wb_tgt[i] = wb_target_in[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        commit_valid_out = (ent_st[head] == ST_DONE);
        flush_out        = commit_valid_out && ent_mp[head];
        commit_idx_out   = head;
        commit_rd_out    = commit_valid_out ? ent_rd[head] : 5'd0;
        commit_data_out  = commit_valid_out ? ent_data[head] : '0;
        commit_we_out    = commit_valid_out && ent_has[head] && (ent_rd[head] != 5'd0);
        flush_pc_out     = flush_out ? ent_tgt[head] : '0;
        alloc_ready_out  = (count < (IW+1)'(DEPTH)) && !flush_out;
        alloc_idx_out    = tail;
        alloc_fire       = alloc_valid_in && alloc_ready_out;
        count_out        = count;
        flush_mask_out   = '0;
        if (flush_out) begin
            for (int i = 0; i < DEPTH; i++)
                flush_mask_out[i] = (ent_st[i] != ST_EMPTY) && (IW'(i) != head);
        end
    end

    always_comb begin
        q1_ready_out = 1'b0;
        q1_data_out  = '0;
        if (ent_st[q1_idx_in] == ST_DONE) begin
            q1_ready_out = 1'b1;
            q1_data_out  = ent_data[q1_idx_in];
        end else if (ent_st[q1_idx_in] == ST_PENDING && wb_hit[q1_idx_in]) begin
            q1_ready_out = 1'b1;
            q1_data_out  = wb_val[q1_idx_in];
        end
    end

    always_comb begin
        q2_ready_out = 1'b0;
        q2_data_out  = '0;
        if (ent_st[q2_idx_in] == ST_DONE) begin
            q2_ready_out = 1'b1;
            q2_data_out  = ent_data[q2_idx_in];
        end else if (ent_st[q2_idx_in] == ST_PENDING && wb_hit[q2_idx_in]) begin
            q2_ready_out = 1'b1;
            q2_data_out  = wb_val[q2_idx_in];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_st[i]   <= ST_EMPTY;
                ent_has[i]  <= 1'b0;
                ent_rd[i]   <= '0;
                ent_data[i] <= '0;
                ent_mp[i]   <= 1'b0;
                ent_tgt[i]  <= '0;
            end
        end else if (flush_out) begin
            // Everything younger than the mispredicted branch is squashed.
            for (int i = 0; i < DEPTH; i++)
                ent_st[i] <= ST_EMPTY;
            head  <= head + IW'(1);
            tail  <= head + IW'(1);
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_hit[i] && ent_st[i] == ST_PENDING) begin
                    ent_st[i]   <= ST_DONE;
                    ent_data[i] <= wb_val[i];
                    ent_mp[i]   <= wb_mp[i];
                    ent_tgt[i]  <= wb_tgt[i];
                end
            end
            if (commit_valid_out) begin
                ent_st[head] <= ST_EMPTY;
                head         <= head + IW'(1);
            end
            if (alloc_fire) begin
                ent_st[tail]  <= ST_PENDING;
                ent_has[tail] <= alloc_has_rd_in;
                ent_rd[tail]  <= alloc_rd_in;
                ent_mp[tail]  <= 1'b0;
                tail          <= tail + IW'(1);
            end
            count <= count + {{IW{1'b0}}, alloc_fire} - {{IW{1'b0}}, commit_valid_out};
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: an in-order queue model predicts commits,
// flushes, lookups and occupancy every cycle.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        alloc_valid, alloc_has_rd;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic [1:0]  wb_valid;
    logic [5:0]  wb_idx;
    logic [63:0] wb_data;
    logic [1:0]  wb_mp;
    logic [63:0] wb_tgt;
    logic [2:0]  q1_idx, q2_idx;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_data, q2_data;
    logic        commit_valid, commit_we;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [2:0]  commit_idx;
    logic        flush;
    logic [31:0] flush_pc;
    logic [7:0]  flush_mask;
    logic [3:0]  count;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .alloc_valid_in(alloc_valid), .alloc_has_rd_in(alloc_has_rd), .alloc_rd_in(alloc_rd),
        .alloc_ready_out(alloc_ready), .alloc_idx_out(alloc_idx),
        .wb_valid_in(wb_valid), .wb_idx_in(wb_idx), .wb_data_in(wb_data),
        .wb_mispredict_in(wb_mp), .wb_target_in(wb_tgt),
        .q1_idx_in(q1_idx), .q2_idx_in(q2_idx),
        .q1_ready_out(q1_ready), .q2_ready_out(q2_ready),
        .q1_data_out(q1_data), .q2_data_out(q2_data),
        .commit_valid_out(commit_valid), .commit_we_out(commit_we), .commit_rd_out(commit_rd),
        .commit_data_out(commit_data), .commit_idx_out(commit_idx),
        .flush_out(flush), .flush_pc_out(flush_pc), .flush_mask_out(flush_mask),
        .count_out(count)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: queue of live indices in program order plus per-index contents.
    logic [2:0]  sq[$];
    logic        m_valid [8];
    logic        m_done  [8];
    logic        m_has   [8];
    logic [4:0]  m_rd    [8];
    logic [31:0] m_data  [8];
    logic        m_mpr   [8];
    logic [31:0] m_tgt   [8];
    logic [2:0]  m_tail;
    int          m_count;

    task automatic model_reset();
        sq.delete();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_done[i] = 0; m_has[i] = 0; m_rd[i] = 0;
            m_data[i] = 0; m_mpr[i] = 0; m_tgt[i] = 0;
        end
        m_tail  = 0;
        m_count = 0;
    endtask

    task automatic clr_in();
        alloc_valid = 0; alloc_has_rd = 0; alloc_rd = 0;
        wb_valid = 0; wb_idx = 0; wb_data = 0; wb_mp = 0; wb_tgt = 0;
        q1_idx = 0; q2_idx = 0;
    endtask

    task automatic set_wb(input int p, input logic [2:0] idx, input logic [31:0] d,
                          input logic mp, input logic [31:0] tgt);
        wb_valid[p]          = 1'b1;
        wb_idx[p*3 +: 3]     = idx;
        wb_data[p*32 +: 32]  = d;
        wb_mp[p]             = mp;
        wb_tgt[p*32 +: 32]   = tgt;
    endtask

    task automatic set_alloc(input logic has, input logic [4:0] rd);
        alloc_valid = 1; alloc_has_rd = has; alloc_rd = rd;
    endtask

    task automatic q_exp(input logic [2:0] idx, output logic rdy, output logic [31:0] d);
        rdy = 0; d = 0;
        if (m_valid[idx] && m_done[idx]) begin
            rdy = 1; d = m_data[idx];
        end else if (m_valid[idx]) begin
            for (int p = 0; p < 2; p++) begin
                if (wb_valid[p] && wb_idx[p*3 +: 3] == idx) begin
                    rdy = 1; d = wb_data[p*32 +: 32];
                end
            end
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks, advances model, crosses one edge.
    task automatic tick();
        logic        exp_cv, exp_fl, exp_rdy, qr;
        logic [2:0]  h, wi;
        logic [7:0]  mask, pend;
        logic [31:0] qd;
        #1;
        exp_cv = (sq.size() > 0) && m_done[sq[0]];
        exp_fl = 0; mask = 0; h = 0;
        chk("commit_valid", commit_valid, exp_cv);
        if (exp_cv) begin
            h = sq[0];
            chk("commit_idx", commit_idx, h);
            chk("commit_rd", commit_rd, m_rd[h]);
            chk("commit_data", commit_data, m_data[h]);
            chk("commit_we", commit_we, m_has[h] && m_rd[h] != 0);
            exp_fl = m_mpr[h];
            if (exp_fl) for (int j = 1; j < sq.size(); j++) mask[sq[j]] = 1'b1;
        end else begin
            chk("commit_we_idle", commit_we, 0);
        end
        chk("flush", flush, exp_fl);
        chk("flush_pc", flush_pc, exp_fl ? m_tgt[h] : 32'h0);
        chk("flush_mask", flush_mask, mask);
        chk("count", count, m_count);
        exp_rdy = (m_count < 8) && !exp_fl;
        chk("alloc_ready", alloc_ready, exp_rdy);
        if (alloc_valid) chk("alloc_idx", alloc_idx, m_tail);
        q_exp(q1_idx, qr, qd);
        chk("q1_ready", q1_ready, qr);
        chk("q1_data", q1_data, qd);
        q_exp(q2_idx, qr, qd);
        chk("q2_ready", q2_ready, qr);
        chk("q2_data", q2_data, qd);

        for (int i = 0; i < 8; i++) pend[i] = m_valid[i] && !m_done[i];
        if (exp_fl) begin
            for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_done[i] = 0; end
            sq.delete();
            m_tail  = h + 3'd1;
            m_count = 0;
        end else begin
            if (exp_cv) begin
                void'(sq.pop_front());
                m_valid[h] = 0; m_done[h] = 0;
                m_count--;
            end
            for (int p = 0; p < 2; p++) begin
                wi = wb_idx[p*3 +: 3];
                if (wb_valid[p] && pend[wi]) begin
                    m_done[wi] = 1;
                    m_data[wi] = wb_data[p*32 +: 32];
                    m_mpr[wi]  = wb_mp[p];
                    m_tgt[wi]  = wb_tgt[p*32 +: 32];
                end
            end
            if (alloc_valid && exp_rdy) begin
                sq.push_back(m_tail);
                m_valid[m_tail] = 1; m_done[m_tail] = 0; m_mpr[m_tail] = 0;
                m_has[m_tail] = alloc_has_rd; m_rd[m_tail] = alloc_rd;
                m_tail = m_tail + 3'd1;
                m_count++;
            end
        end
        @(posedge clk_in);
        #1;
        clr_in();
    endtask

    task automatic reset_dut();
        clr_in();
        rst_in = 0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_alloc_idx", alloc_idx, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_we", commit_we, 0);
        chk("rst_commit_data", commit_data, 0);
        chk("rst_flush", flush, 0);
        chk("rst_flush_mask", flush_mask, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_q1_ready", q1_ready, 0);
        chk("rst_q2_ready", q2_ready, 0);
        chk("rst_q1_data", q1_data, 0);
        @(posedge clk_in);
        #1;
        rst_in = 1;
        model_reset();
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sq.size() > 0; n++) tick();
        chk("drain_left", sq.size(), 0);
    endtask

    logic [2:0] prev;

    initial begin
        clr_in();
        model_reset();
        #1;
        reset_dut();

        // Fill to capacity, then a ninth request must be refused.
        for (int i = 0; i < 8; i++) begin
            set_alloc(1, 5'(i + 1));
            tick();
        end
        chk("fill_count", count, 8);
        set_alloc(1, 5'd9);
        tick();
        for (int i = 0; i < 8; i++) begin
            set_wb(i % 2, 3'(i), 32'h100 + i, 0, 0);
            tick();
        end
        drain();

        // Out-of-order completion, in-order retirement.
        set_alloc(1, 5'd5); tick();
        set_alloc(1, 5'd6); tick();
        set_alloc(1, 5'd7); tick();
        set_wb(0, 3'd2, 32'h33, 0, 0); q1_idx = 3'd2; tick();
        set_wb(1, 3'd0, 32'h11, 0, 0); q2_idx = 3'd2; tick();
        set_wb(0, 3'd1, 32'h22, 0, 0); tick();
        drain();

        // Streaming alloc/complete pairs across the index wrap, some without a destination.
        prev = 0;
        for (int k = 0; k < 12; k++) begin
            set_alloc(k % 3 != 0, 5'(k % 8));
            if (k > 0) set_wb(1, prev, 32'h1000 + k, 0, 0);
            prev = m_tail;
            tick();
            chk("wrap_count_le8", count <= 8, 1);
        end
        set_wb(0, prev, 32'h2000, 0, 0);
        tick();
        drain();

        // Mispredicted branch at index 1 squashes 2..4; stray alloc/wb that cycle are dropped.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            set_alloc(1, 5'(10 + i));
            tick();
        end
        set_wb(0, 3'd1, 32'hBEEF, 1, 32'h100); tick();
        set_wb(1, 3'd0, 32'h55, 0, 0); tick();
        tick();
        chk("mp_flush", flush, 1);
        chk("mp_mask", flush_mask, 8'b0001_1100);
        set_alloc(1, 5'd3);
        set_wb(0, 3'd2, 32'h77, 0, 0);
        tick();
        chk("mp_count_after", count, 0);
        chk("mp_tail_after", alloc_idx, 2);
        set_alloc(1, 5'd4);
        tick();
        set_wb(0, 3'd2, 32'h88, 0, 0);
        tick();
        drain();

        // Two ports hit the same entry: the higher port wins, also on the bypass path.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            set_alloc(1, 5'(20 + i));
            tick();
        end
        set_wb(0, 3'd3, 32'hA, 0, 0);
        set_wb(1, 3'd3, 32'hB, 0, 0);
        q1_idx = 3'd3;
        #1;
        chk("byp_q1_ready", q1_ready, 1);
        chk("byp_q1_data", q1_data, 32'hB);
        tick();
        set_wb(0, 3'd3, 32'hC, 0, 0); q1_idx = 3'd3; tick();
        set_wb(0, 3'd0, 32'h1, 0, 0); set_wb(1, 3'd1, 32'h2, 0, 0); tick();
        set_wb(1, 3'd2, 32'h3, 0, 0); tick();
        drain();

        // Asynchronous reset landing between edges mid-fill.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            set_alloc(1, 5'(i + 1));
            tick();
        end
        chk("midfill_count", count, 5);
        #2;
        reset_dut();
        set_alloc(1, 5'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end by 200000");
        $fatal(1);
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count, power of two, 4..32; IW = log2(DEPTH).
REQ-002 SHALL have parameter WB_PORTS, default 2, number of writeback ports, 1..4.
REQ-003 SHALL have parameter DATA_W, default 32, result/target width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low (clk_in, rst_in).
REQ-005 SHALL have ports:
- clk_in  in  1  clock
- rst_in  in  1  async active-low reset
- alloc_valid_in  in  1  allocate request
- alloc_has_rd_in  in  1  entry writes a register
- alloc_rd_in  in  5  destination register
- alloc_ready_out  out  1  allocation accepted this cycle
- alloc_idx_out  out  IW  index given to the current request (tail)
- wb_valid_in  in  WB_PORTS  writeback strobe per port
- wb_idx_in  in  WB_PORTS*IW  target entry per port
- wb_data_in  in  WB_PORTS*DATA_W  result per port
- wb_mispredict_in  in  WB_PORTS  branch mispredicted
- wb_target_in  in  WB_PORTS*DATA_W  corrected PC
- q1_idx_in, q2_idx_in  in  IW  operand lookup
- q1_ready_out, q2_ready_out  out  1  entry result available
- q1_data_out, q2_data_out  out  DATA_W  entry result
- commit_valid_out  out  1  head retires this cycle
- commit_we_out  out  1  commit writes register file
- commit_rd_out  out  5  register written
- commit_data_out  out  DATA_W  value written
- commit_idx_out  out  IW  retiring entry index
- flush_out  out  1  pipeline flush
- flush_pc_out  out  DATA_W  redirect PC
- flush_mask_out  out  DEPTH  entries squashed (one bit per index)
- count_out  out  IW+1  occupied entries

Function
REQ-006 SHALL be a circular buffer: head (oldest), tail (next free), count; indices wrap modulo DEPTH.
REQ-007 SHALL hold per entry: state {EMPTY, PENDING, DONE}, has_rd, rd, data, mispredict, target.
REQ-008 alloc_ready_out SHALL be 1 iff count < DEPTH and flush_out = 0; it SHALL NOT depend on same-cycle commit.
REQ-009 On alloc_valid_in & alloc_ready_out: entry[tail] <= PENDING with rd/has_rd, tail++, count++ at the edge; alloc_idx_out = tail (combinational).
REQ-010 Writeback on port p with entry PENDING: entry <= DONE, data/mispredict/target latched at the edge; writeback to an EMPTY or DONE entry SHALL be ignored.
REQ-011 Two ports same index same cycle: highest port number SHALL win.
REQ-012 Allocation and writeback to the same index same cycle cannot occur (entry is EMPTY); writeback ignored.
REQ-013 commit_valid_out SHALL be 1 iff entry[head] is DONE; it is combinational from registered state (earliest: cycle after writeback); at the edge head++, count--, entry <= EMPTY.
REQ-014 commit_we_out = commit_valid_out & has_rd; commit_rd_out/commit_data_out/commit_idx_out from head; rd = 0 SHALL force commit_we_out = 0.
REQ-015 Exactly one commit per cycle maximum.
REQ-016 If committing head has mispredict: flush_out = 1 same cycle, flush_pc_out = head target, flush_mask_out = all non-EMPTY entries except head; at the edge all entries EMPTY, tail <= head+1, head <= head+1, count <= 0; alloc and writebacks that cycle SHALL be discarded.
REQ-017 flush_out = 0 ⇒ flush_mask_out = 0, flush_pc_out = 0.
REQ-018 Simultaneous alloc and commit (no flush): count unchanged.
REQ-019 qN_ready_out = 1 if entry DONE, or entry PENDING with a matching same-cycle writeback (bypass, highest port wins); qN_data_out accordingly, else 0.
REQ-020 count_out SHALL equal registered count.

Reset
REQ-021 rst_in low SHALL immediately clear head, tail, count to 0 and all entries to EMPTY, mid-operation included.
REQ-022 During/after reset: alloc_ready_out = 1 (rst_in high), alloc_idx_out = 0, commit_valid_out = 0, commit_we_out = 0, flush_out = 0, flush_mask_out = 0, q*_ready_out = 0, count_out = 0, data outputs 0.

Verification
REQ-023 Fill: 8 allocs, no writeback -> alloc_idx 0..7, count_out = 8, alloc_ready_out = 0 on ninth.
REQ-024 Out-of-order wb: alloc 0,1,2 (rd 5,6,7); wb idx2 = 0x33, idx0 = 0x11, idx1 = 0x22 on consecutive cycles -> commits rd5=0x11, then rd6=0x22, rd7=0x33, in order.
REQ-025 Wrap: run 12 alloc/commit pairs -> alloc_idx wraps 7->0, count never exceeds 8, data order preserved.
REQ-026 Mispredict: alloc 0..4, wb idx1 mispredict target 0x100, wb idx0 -> commit idx0, then commit idx1 with flush_out = 1, flush_pc_out = 0x100, flush_mask_out = 0b11100; next cycle count_out = 0, alloc_idx_out = 2.
REQ-027 Bypass/conflict: same-cycle wb idx3 on ports 0 (0xA) and 1 (0xB) with q1_idx = 3 -> q1_ready_out = 1, q1_data_out = 0xB; later commit data 0xB.
REQ-028 Async reset mid-fill (count 5) between clock edges -> outputs at REQ-022 values before next edge.
